// File: rtl/iexecute.sv
// iexecute: MIPS execute stage (ALU control, ALU, operand/dest select, branch target) feeding an EX/MEM register.
// Inputs: clk, reset (sync, high), flush, nPC, A, B, SE, RT, RD, ALUOp and ID/EX control bits.
// Outputs: registered BranchTarget, ALUResult, Zero, WriteData, WriteAddress and the five control bits.
// Optional: EX_FORWARD_EN adds FwdA/FwdB selects plus ExMemResult/MemWbResult forwarding inputs.
module iexecute (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] nPC,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] SE,
  input  logic [4:0]  RT,
  input  logic [4:0]  RD,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        RegDst,
`ifdef EX_FORWARD_EN
  input  logic [1:0]  FwdA,
  input  logic [1:0]  FwdB,
  input  logic [31:0] ExMemResult,
  input  logic [31:0] MemWbResult,
`endif
  output logic [31:0] BranchTarget,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteAddress,
  output logic        BranchOut,
  output logic        MemReadOut,
  output logic        MemWriteOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut
);
  logic [31:0] op_a, op_b_fwd, op_b, alu_d, bt_d;
  logic [31:0] bt_q, alu_q, wd_q;
  logic [4:0]  wa_d, wa_q, ctl_d, ctl_q;
  logic        zero_q;
  logic [5:0]  funct;
  always_comb begin
`ifdef EX_FORWARD_EN
    op_a     = FwdA[1] ? ExMemResult : FwdA[0] ? MemWbResult : A;
    op_b_fwd = FwdB[1] ? ExMemResult : FwdB[0] ? MemWbResult : B;
`else
    op_a     = A;
    op_b_fwd = B;
`endif
    op_b  = ALUSrc ? SE : op_b_fwd;
    funct = SE[5:0];
    alu_d = ALUOp == 2'b01 ? op_a - op_b :
            ALUOp != 2'b10 ? op_a + op_b :
            funct == 6'b100000 ? op_a + op_b :
            funct == 6'b100010 ? op_a - op_b :
            funct == 6'b100100 ? op_a & op_b :
            funct == 6'b100101 ? op_a | op_b :
            funct == 6'b101010 ? {31'd0, $signed(op_a) < $signed(op_b)} : 32'd0;
    bt_d  = nPC + {SE[29:0], 2'b00};
    wa_d  = RegDst ? RD : RT;
    ctl_d = flush ? 5'd0 : {Branch, MemRead, MemWrite, MemtoReg, RegWrite};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bt_q   <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
      wd_q   <= '0;
      wa_q   <= '0;
      ctl_q  <= '0;
    end else begin
      bt_q   <= bt_d;
      alu_q  <= alu_d;
      zero_q <= alu_d == 32'd0;
      wd_q   <= op_b_fwd;
      wa_q   <= wa_d;
      ctl_q  <= ctl_d;
    end
  end
  assign BranchTarget = bt_q;
  assign ALUResult    = alu_q;
  assign Zero         = zero_q;
  assign WriteData    = wd_q;
  assign WriteAddress = wa_q;
  assign {BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut} = ctl_q;
endmodule

// File: tb/tb_iexecute.sv
// tb_iexecute: directed scoreboard bench for the execute stage.
module tb_iexecute;
  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] nPC, A, B, SE;
  logic [4:0]  RT, RD;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst;
`ifdef EX_FORWARD_EN
  logic [1:0]  FwdA, FwdB;
  logic [31:0] ExMemResult, MemWbResult;
`endif
  logic [31:0] BranchTarget, ALUResult, WriteData;
  logic        Zero;
  logic [4:0]  WriteAddress;
  logic        BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut;
  typedef struct packed {
    logic [31:0] bt;
    logic [31:0] alu;
    logic        z;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic [4:0]  ctl;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  iexecute dut (
    .clk(clk), .reset(reset), .flush(flush), .nPC(nPC), .A(A), .B(B), .SE(SE),
    .RT(RT), .RD(RD), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .RegDst(RegDst),
`ifdef EX_FORWARD_EN
    .FwdA(FwdA), .FwdB(FwdB), .ExMemResult(ExMemResult), .MemWbResult(MemWbResult),
`endif
    .BranchTarget(BranchTarget), .ALUResult(ALUResult), .Zero(Zero),
    .WriteData(WriteData), .WriteAddress(WriteAddress), .BranchOut(BranchOut),
    .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    reset = 0; flush = 0; nPC = 0; A = 0; B = 0; SE = 0; RT = 0; RD = 0; ALUOp = 0;
    ALUSrc = 0; Branch = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; RegDst = 0;
`ifdef EX_FORWARD_EN
    FwdA = 0; FwdB = 0; ExMemResult = 0; MemWbResult = 0;
`endif
  endtask
  task automatic push(input logic [31:0] bt, input logic [31:0] alu, input logic z,
                      input logic [31:0] wd, input logic [4:0] wa, input logic [4:0] ctl);
    sb.push_back('{bt: bt, alu: alu, z: z, wd: wd, wa: wa, ctl: ctl});
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_bt"}, BranchTarget, e.bt);
      chk({tag, "_alu"}, ALUResult, e.alu);
      chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, e.z});
      chk({tag, "_wd"}, WriteData, e.wd);
      chk({tag, "_wa"}, {27'd0, WriteAddress}, {27'd0, e.wa});
      chk({tag, "_ctl"}, {27'd0, BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut},
          {27'd0, e.ctl});
    end
  endtask
  initial begin
    idle();
    reset = 1; flush = 1; A = 5; B = 7; SE = 32'h20; ALUOp = 2'b10; RD = 3; RegDst = 1;
    RegWrite = 1; Branch = 1; MemRead = 1; nPC = 32'h44;
    push(0, 0, 0, 0, 0, 0); tick("reset");
    idle(); A = 5; B = 7; ALUOp = 2'b10; SE = 32'h20; RegDst = 1; RD = 3; RT = 9; RegWrite = 1; nPC = 32'h10;
    push(32'h90, 12, 0, 7, 3, 5'b00001); tick("radd");
    idle(); A = 32'h1234; B = 32'h1234; ALUOp = 2'b01; Branch = 1; nPC = 32'h100; SE = 32'hFFFFFFFF; RT = 4; RD = 7;
    push(32'hFC, 0, 1, 32'h1234, 4, 5'b10000); tick("beq");
    idle(); A = 32'hFFFFFFFF; B = 1; ALUOp = 2'b10; SE = 32'h2A;
    push(32'hA8, 1, 0, 1, 0, 0); tick("slt_neg");
    idle(); A = 1; B = 32'hFFFFFFFF; ALUOp = 2'b10; SE = 32'h2A;
    push(32'hA8, 0, 1, 32'hFFFFFFFF, 0, 0); tick("slt_pos");
    idle(); ALUSrc = 1; A = 32'h40; SE = 8; B = 32'hDEAD; MemWrite = 1; flush = 1; nPC = 32'h200; RT = 6;
    push(32'h220, 32'h48, 0, 32'hDEAD, 6, 0); tick("sw_flush");
    idle(); A = 3; B = 5; ALUOp = 2'b10; SE = 32'h22; RegDst = 1; RD = 31; RegWrite = 1; flush = 1;
    push(32'h88, 32'hFFFFFFFE, 0, 5, 31, 0); tick("sub_flush2");
    idle(); A = 32'hF0F0; B = 32'hFF00; ALUOp = 2'b10; SE = 32'h24; RegDst = 1; RD = 2; RegWrite = 1;
    push(32'h90, 32'hF000, 0, 32'hFF00, 2, 5'b00001); tick("and");
    idle(); A = 32'hF0F0; B = 32'hFF00; ALUOp = 2'b10; SE = 32'h25; MemtoReg = 1;
    push(32'h94, 32'hFFF0, 0, 32'hFF00, 0, 5'b00010); tick("or");
    idle(); A = 5; B = 7; ALUOp = 2'b10; SE = 0; RT = 1;
    push(0, 0, 1, 7, 1, 0); tick("bad_funct");
    idle(); A = 32'hFFFFFFFF; B = 9; SE = 1; ALUSrc = 1; ALUOp = 2'b11; nPC = 32'hFFFFFFFC; MemRead = 1; MemtoReg = 1;
    push(0, 0, 1, 9, 0, 5'b01010); tick("wrap");
    idle(); A = 2; B = 3; ALUOp = 2'b00; RD = 5; RegDst = 1; RegWrite = 1; reset = 1; nPC = 8;
    push(0, 0, 0, 0, 0, 0); tick("midreset");
    reset = 0;
    push(32'h8, 5, 0, 3, 5, 5'b00001); tick("after_reset");
`ifdef EX_FORWARD_EN
    idle(); A = 1; B = 2; ExMemResult = 10; MemWbResult = 20; FwdA = 2'b10; FwdB = 2'b01; ALUOp = 2'b10; SE = 32'h20;
    push(32'h80, 30, 0, 20, 0, 0); tick("fwd_a10_b01");
    FwdA = 2'b11;
    push(32'h80, 30, 0, 20, 0, 0); tick("fwd_a11");
    FwdA = 2'b00; FwdB = 2'b11;
    push(32'h80, 11, 0, 10, 0, 0); tick("fwd_b11");
    FwdB = 2'b10; ALUSrc = 1; ALUOp = 2'b00; SE = 4;
    push(32'h10, 5, 0, 10, 0, 0); tick("fwd_alusrc");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iexecute.md
# iExecute

Execute stage of the five-stage MIPS pipeline. Consumes the ID/EX register outputs produced by the decode stage, performs ALU control decoding, ALU operation, second-operand selection, branch-target computation and destination-register selection, then captures all results in an internal EX/MEM pipeline register. The memory stage consumes its outputs.

## Interface
- No parameters; datapath width is `WORD (32) from definitions.vh.
- clk  in  1  pipeline clock, rising-edge active
- reset  in  1  synchronous, active-high; clears the EX/MEM register
- flush  in  1  squashes the instruction entering EX/MEM (control bits forced to 0)
- nPC  in  `WORD  PC+4 of the instruction in EX
- A, B  in  `WORD  register operands rs, rt
- SE  in  `WORD  sign-extended immediate; SE[5:0] is funct
- RT, RD  in  5  candidate destination registers
- ALUOp  in  2  from control
- ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst  in  1 each  control from ID/EX
- BranchTarget  out  `WORD  registered nPC + (SE << 2)
- ALUResult  out  `WORD  registered ALU output
- Zero  out  1  registered (ALU result == 0)
- WriteData  out  `WORD  registered store data (operand B after forwarding)
- WriteAddress  out  5  registered destination register
- BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut  out  1 each  registered control
- Only with EX_FORWARD_EN: FwdA, FwdB  in  2; ExMemResult, MemWbResult  in  `WORD

## Operation
- Operand 1 = A (or forwarded value). Operand 2 = SE if ALUSrc=1, else B (or forwarded value).
- ALU control: ALUOp 00 → add; 01 → sub; 11 → add; 10 → by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed; result 1 or 0). Any other funct → result 0.
- add/sub are 32-bit modular. Overflow is ignored and raises no flag.
- Zero = (ALU result == 32'h0), computed before the register.
- BranchTarget = nPC + {SE[29:0], 2'b00}, 32-bit modular (wraps silently).
- WriteAddress = RD if RegDst=1, else RT.
- WriteData = operand B before the ALUSrc mux. It is never SE.
- The branch decision (Branch & Zero) is not made here; the memory stage makes it.
- The block has one internal state element, the EX/MEM register. It has no FSM.

## Timing
- Latency is 1 cycle: inputs present before rising edge N appear on the outputs after edge N.
- The register loads every cycle; there is no stall/enable input.
- reset=1 at an edge clears every output to 0, including BranchTarget, ALUResult, Zero, WriteData and WriteAddress.
- flush=1 at an edge (reset=0):
  - BranchOut, MemReadOut, MemWriteOut, MemtoRegOut and RegWriteOut load 0.
  - Data outputs load normally.
- reset has priority over flush. flush held on consecutive cycles squashes each of those instructions.
- reset asserted mid-stream discards the in-flight instruction. The first valid output appears 1 cycle after the first edge with reset=0.

## Configuration
- Macro: EX_FORWARD_EN.
- Defined: the FwdA/FwdB/ExMemResult/MemWbResult ports exist.
  - Select encoding: 00 → ID/EX value, 10 → ExMemResult, 01 → MemWbResult, 11 → ExMemResult (EX/MEM wins).
  - The forwarded B feeds both the ALUSrc mux and WriteData.
- Undefined: the ports are absent and operands come directly from A and B. Behaviour is otherwise identical.

## Test plan
- R-type add: A=5, B=7, ALUOp=10, SE[5:0]=100000, RegDst=1, RD=3, RegWrite=1 → next cycle ALUResult=12, Zero=0, WriteAddress=3, RegWriteOut=1.
- beq taken: A=B=0x1234, ALUOp=01, Branch=1, nPC=0x100, SE=0xFFFFFFFF → ALUResult=0, Zero=1, BranchTarget=0xFC, BranchOut=1.
- slt signed: A=0xFFFFFFFF, B=1, funct 101010 → ALUResult=1. Swap operands → ALUResult=0.
- sw with flush: ALUSrc=1, A=0x40, SE=8, B=0xDEAD, MemWrite=1, flush=1 → ALUResult=0x48, WriteData=0xDEAD, MemWriteOut=0.
- reset: with valid inputs and reset=1 (flush=1 too), all outputs 0 after the edge. Release reset → the next edge loads inputs normally.
- EX_FORWARD_EN: A=1, ExMemResult=10, MemWbResult=20, FwdA=10, FwdB=01, B=2, funct add → ALUResult=30. FwdA=11 → EX/MEM value used.
